// File: rtl/afifo_rd_ptr_ctrl.sv
// afifo_rd_ptr_ctrl
//   Read-side pointer / empty controller of the asynchronous FIFO.
//   Brings the write-domain gray pointer across into clk, converts it to
//   binary, keeps the local read pointer, and derives empty, fill count and
//   underflow. The gray read pointer is published back to the write domain.
//
// Parameters
//   ADDR_WIDTH          memory address width; pointers are ADDR_WIDTH+1 bits
//   SYNC_STAGES         flops on wr_ptr_gray_i (2..4)
//   ALMOST_EMPTY_THRESH almost_empty_o threshold (optional feature only)
//
// Ports
//   clk            read-domain clock
//   rst_n          async active-low reset
//   rd_en_i        read request
//   wr_ptr_gray_i  gray write pointer, asynchronous to clk
//   rd_ptr_gray_o  registered gray read pointer to the write domain
//   rd_addr_o      memory read address (low bits of binary read pointer)
//   empty_o        registered empty flag
//   count_o        registered fill level, 0..2^ADDR_WIDTH
//   underflow_o    one-cycle pulse on a read request while empty
//   almost_empty_o registered, only when AFIFO_ALMOST_EMPTY_EN is defined
//
// Build option
//   AFIFO_ALMOST_EMPTY_EN  adds almost_empty_o (fill <= ALMOST_EMPTY_THRESH)
module afifo_rd_ptr_ctrl #(
  parameter int ADDR_WIDTH          = 4,
  parameter int SYNC_STAGES         = 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_i,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  underflow_o
`ifdef AFIFO_ALMOST_EMPTY_EN
  ,
  output logic                  almost_empty_o
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Plain flop chain: nothing may sit between stages or the metastability
  // settling time is eaten.
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] wr_gray_sync, wr_bin_sync;

  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          underflow_q, underflow_d;
  logic          rd_fire;

  assign wr_gray_sync = sync_q[SYNC_STAGES-1];
  assign wr_bin_sync  = gray2bin(wr_gray_sync);

  // Gating on the registered empty keeps rd_fire off any long comb path
  // back through the synchronised pointer compare.
  assign rd_fire = rd_en_i & ~empty_q;

  always_comb begin
    rd_bin_d    = rd_bin_q + {{ADDR_WIDTH{1'b0}}, rd_fire};
    rd_gray_d   = rd_bin_d ^ (rd_bin_d >> 1);
    // Empty uses the next pointer so the last-entry read raises empty on the
    // same edge the pointer advances; a full-width gray compare also tells
    // empty (MSB equal) apart from full (MSB different).
    empty_d     = (rd_gray_d == wr_gray_sync);
    count_d     = wr_bin_sync - rd_bin_d;
    underflow_d = rd_en_i & empty_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      empty_q     <= 1'b1;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      sync_q[0] <= wr_ptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      empty_q     <= empty_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_ptr_gray_o = rd_gray_q;
  assign rd_addr_o     = rd_bin_q[ADDR_WIDTH-1:0];
  assign empty_o       = empty_q;
  assign count_o       = count_q;
  assign underflow_o   = underflow_q;

`ifdef AFIFO_ALMOST_EMPTY_EN
  localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

  logic almost_empty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_empty_q <= 1'b1;
    else        almost_empty_q <= (count_d <= AE_THRESH);
  end

  assign almost_empty_o = almost_empty_q;
`else
  // Threshold has no consumer in this build.
  logic [31:0] unused_ae_thresh;
  assign unused_ae_thresh = 32'(ALMOST_EMPTY_THRESH);
`endif

endmodule

// File: tb/tb_afifo_rd_ptr_ctrl.sv
// Directed bench for afifo_rd_ptr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2).
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT output is sampled (#1 after the rising edge).
module tb_afifo_rd_ptr_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rd_en;
  logic [4:0] wr_gray;
  logic [4:0] rd_gray;
  logic [3:0] rd_addr;
  logic       empty;
  logic [4:0] count;
  logic       underflow;
`ifdef AFIFO_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  afifo_rd_ptr_ctrl #(
    .ADDR_WIDTH(4), .SYNC_STAGES(2), .ALMOST_EMPTY_THRESH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_en_i       (rd_en),
    .wr_ptr_gray_i (wr_gray),
    .rd_ptr_gray_o (rd_gray),
    .rd_addr_o     (rd_addr),
    .empty_o       (empty),
    .count_o       (count),
    .underflow_o   (underflow)
`ifdef AFIFO_ALMOST_EMPTY_EN
    ,
    .almost_empty_o(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [4:0] g5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard: observed %0h with no expectation queued", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
    end
  endtask

  // empty/count pair
  task automatic exp_ec(input string tag, input logic e, input logic [4:0] c);
    expect_v({tag, "_empty"}, 32'(e));
    expect_v({tag, "_count"}, 32'(c));
  endtask

  task automatic chk_ec();
    check_v(32'(empty));
    check_v(32'(count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    logic [4:0] prev;
    rd_en   = 1'b0;
    wr_gray = 5'b0;

    // ---- initial reset ----
    #1 rst_n = 1'b0;
    #2;
    exp_ec("por", 1'b1, 5'd0);
    chk_ec();
`ifdef AFIFO_ALMOST_EMPTY_EN
    expect_v("por_ae", 1); check_v(32'(almost_empty));
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // ---- three writes, exactly 3-cycle visibility ----
    wr_gray = 5'b00010;                 // bin 3
    tick(); exp_ec("wr3_c1", 1'b1, 5'd0); chk_ec();
    tick(); exp_ec("wr3_c2", 1'b1, 5'd0); chk_ec();
    tick(); exp_ec("wr3_c3", 1'b0, 5'd3); chk_ec();

    // ---- three reads ----
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_v("rd3_addr", 32'(i)); check_v(32'(rd_addr));
      tick();
    end
    exp_ec("rd3_done", 1'b1, 5'd0); chk_ec();
    expect_v("rd3_gray", 32'h02); check_v(32'(rd_gray));
    expect_v("rd3_uf", 0);        check_v(32'(underflow));

    // ---- underflow: rd_en held while empty ----
    tick();
    expect_v("uf_pulse", 1); check_v(32'(underflow));
    expect_v("uf_gray", 32'h02); check_v(32'(rd_gray));
    expect_v("uf_addr", 3);      check_v(32'(rd_addr));
    rd_en = 1'b0;
    tick();
    expect_v("uf_clear", 0); check_v(32'(underflow));
    expect_v("uf_addr2", 3); check_v(32'(rd_addr));

    // ---- advance read pointer to 24 ----
    wr_gray = g5(24);
    tick(); tick(); tick();
    exp_ec("pre24", 1'b0, 5'd21); chk_ec();
    rd_en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      expect_v("pre24_addr", 32'((3 + i) % 16)); check_v(32'(rd_addr));
      tick();
    end
    rd_en = 1'b0;
    exp_ec("at24", 1'b1, 5'd0); chk_ec();
    expect_v("at24_gray", 32'h14); check_v(32'(rd_gray));

    // ---- full (16) and wrap ----
    wr_gray = 5'b01100;                 // gray(8)
    tick(); tick(); tick();
    exp_ec("full", 1'b0, 5'd16); chk_ec();
    prev  = rd_gray;
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expect_v("wrap_addr", 32'((24 + i) % 16)); check_v(32'(rd_addr));
      tick();
      expect_v("wrap_gray", 32'(g5((25 + i) % 32))); check_v(32'(rd_gray));
      expect_v("wrap_1bit", 1); check_v(32'($countones(prev ^ rd_gray)));
      expect_v("wrap_empty", 32'(i == 15)); check_v(32'(empty));
      prev = rd_gray;
    end
    rd_en = 1'b0;
    expect_v("wrap_count", 0); check_v(32'(count));

    // ---- simultaneous read and write arrival ----
    wr_gray = g5(9);
    tick(); tick(); tick();
    exp_ec("sim_pre", 1'b0, 5'd1); chk_ec();
    wr_gray = g5(10);
    tick();
    tick();
    exp_ec("sim_mid", 1'b0, 5'd1); chk_ec();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp_ec("sim", 1'b0, 5'd1); chk_ec();
    expect_v("sim_uf", 0);   check_v(32'(underflow));
    expect_v("sim_addr", 9); check_v(32'(rd_addr));

    // ---- asynchronous reset mid-run ----
    #3 rst_n = 1'b0;
    #1;
    exp_ec("arst", 1'b1, 5'd0); chk_ec();
    expect_v("arst_gray", 0); check_v(32'(rd_gray));
    expect_v("arst_addr", 0); check_v(32'(rd_addr));
    expect_v("arst_uf", 0);   check_v(32'(underflow));
    rd_en = 1'b1;                       // must be ignored under reset
    tick();
    exp_ec("arst_hold", 1'b1, 5'd0); chk_ec();
    expect_v("arst_hold_addr", 0); check_v(32'(rd_addr));
    expect_v("arst_hold_uf", 0);   check_v(32'(underflow));
    rd_en = 1'b0;
    rst_n = 1'b1;
    tick(); tick(); tick();
    exp_ec("post_rst", 1'b0, 5'd10); chk_ec();

    // ---- drain 10 -> 1, almost-empty at threshold 2 ----
    rd_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_ec("drain", 1'b0, 5'(9 - i)); chk_ec();
`ifdef AFIFO_ALMOST_EMPTY_EN
      expect_v("ae", 32'((9 - i) <= 2)); check_v(32'(almost_empty));
`endif
    end
    rd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
